slave_rx_engine: RTL and testbench
==================================

SLAVE_RX_ENGINE -- requirements
Module: slave_rx_engine

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, serial address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 8, serial data word width in bits.
REQ-003 The block SHALL have parameter BURST_W, default 12, serial burst-length field width in bits.
REQ-004 The block SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rstn  in  1  reset; asynchronous, active-low.
REQ-006 The block SHALL have port m_valid  in  1  master holds high for the whole transaction.
REQ-007 The block SHALL have port write_enable  in  1  write mode, sampled at start.
REQ-008 The block SHALL have port read_enable  in  1  read mode, sampled at start.
REQ-009 The block SHALL have port rx_address  in  1  serial address, then burst field, MSB first.
REQ-010 The block SHALL have port rx_data  in  1  serial write data, MSB first.
REQ-011 The block SHALL have port s_ready  out  1  high only in IDLE.
REQ-012 The block SHALL have port wr_valid  out  1  write beat valid.
REQ-013 The block SHALL have port wr_ready  in  1  write beat accepted when wr_valid&&wr_ready.
REQ-014 The block SHALL have port rd_valid  out  1  read request valid.
REQ-015 The block SHALL have port rd_ready  in  1  read request accepted when rd_valid&&rd_ready.
REQ-016 The block SHALL have port addr_out  out  ADDR_W  beat address, write or read.
REQ-017 The block SHALL have port data_out  out  DATA_W  write beat data.
REQ-018 The block SHALL have port burst_counter  out  BURST_W  beats remaining.
REQ-019 The block SHALL have port rx_done  out  1  one-cycle completion pulse.
REQ-020 The block SHALL have port err  out  2  sticky: [0] write overflow, [1] protocol error.

Function
REQ-021 FSM states SHALL be IDLE, ADDR, BURST, WDATA, RDREQ, DONE.
REQ-022 Start: IDLE and m_valid=1 at a rising edge; mode latched; rx_address that cycle is address MSB; next state ADDR.
REQ-023 Start with write_enable=read_enable (both 0 or both 1) SHALL set err[1] and stay IDLE.
REQ-024 ADDR shifts ADDR_W-1 further bits, then BURST shifts BURST_W bits; burst value N = beat count.
REQ-025 N=0 SHALL go directly to DONE with no beats; otherwise WDATA (write) or RDREQ (read); burst_counter loads N.
REQ-026 WDATA: each DATA_W bits form one word; word k (k=0..N-1) presented cycle after its last bit with addr_out=base+k mod 2^ADDR_W.
REQ-027 wr_valid SHALL hold until wr_ready; completing a new word while wr_valid still high SHALL overwrite the register and set err[0].
REQ-028 RDREQ: rd_valid high with addr_out=base+k; advance k on rd_ready; wrap mod 2^ADDR_W; may stall indefinitely.
REQ-029 burst_counter SHALL decrement per completed write word or accepted read request, never below 0.
REQ-030 DONE lasts one cycle with rx_done=1, then IDLE; last write word presented same cycle.
REQ-031 m_valid=0 in ADDR/BURST/WDATA/RDREQ SHALL abort to IDLE: partial word dropped, rd_valid cleared, pending wr_valid still delivered, err[1] set, no rx_done.
REQ-032 err bits SHALL clear only by reset.

Reset
REQ-033 rstn=0 SHALL immediately force IDLE and all outputs 0 except s_ready=1, including mid-transaction; shift registers and counters cleared.

Structure
REQ-034 Package serial_bus_pkg SHALL hold the state enum and default ADDR_W/DATA_W/BURST_W constants.
REQ-035 One sub-module sbus_shift_in (parametrised-width MSB-first shifter with bit count and full flag) SHALL be instanced for address, burst and data.

Verification (defaults except BURST_W=4)
REQ-036 Write base 0xA5C, N=2, data 0x3C,0xF0, wr_ready=1 -> beats (0xA5C,0x3C),(0xA5D,0xF0); rx_done one cycle; err=0.
REQ-037 Write base 0xFFF, N=2 -> addresses 0xFFF then 0x000.
REQ-038 Read base 0x010, N=3, rd_ready low 2 cycles then high -> rd_valid holds 0x010, then 0x011, 0x012; burst_counter 3,2,1,0.
REQ-039 Write N=2, wr_ready=0 throughout -> data_out=second word, err[0]=1.
REQ-040 m_valid dropped mid-ADDR, and start with both enables high -> IDLE, err[1]=1, no rx_done, no beats.
REQ-041 rstn low during WDATA beat 1 -> all outputs 0 except s_ready=1 immediately; next transaction completes normally.

Source files
------------

// File: rtl/serial_bus_pkg.sv
// Shared types and default widths for the serial slave receive engine.
package serial_bus_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 8;
  localparam int BURST_W_DEF = 12;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    BURST,
    WDATA,
    RDREQ,
    DONE
  } rx_state_e;

endpackage

// File: rtl/sbus_shift_in.sv
// MSB-first serial-to-parallel shifter with an internal bit count.
// 'full' flags the shift that completes a W-bit word; 'word' shows that word in the same cycle.
module sbus_shift_in #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clear,
  input  logic         shift_en,
  input  logic         bit_in,
  output logic [W-1:0] word,
  output logic         full
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  value_q, value_d, value_nxt;
  logic [CW-1:0] count_q, count_d;

  if (W == 1) begin : g_one
    assign value_nxt = bit_in;
  end else begin : g_multi
    assign value_nxt = {value_q[W-2:0], bit_in};
  end

  assign full = shift_en && (count_q == CW'(W - 1));
  assign word = shift_en ? value_nxt : value_q;

  // The count wraps to zero on the completing shift so back-to-back words need no restart.
  always_comb begin
    value_d = value_q;
    count_d = count_q;
    if (clear) begin
      value_d = '0;
      count_d = '0;
    end else if (shift_en) begin
      value_d = value_nxt;
      count_d = full ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      value_q <= '0;
      count_q <= '0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/slave_rx_engine.sv
// Serial slave receive engine: shifts in address, burst length and write data,
// then issues write beats or read requests with an incrementing, wrapping address.
module slave_rx_engine
  import serial_bus_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               m_valid,
  input  logic               write_enable,
  input  logic               read_enable,
  input  logic               rx_address,
  input  logic               rx_data,
  output logic               s_ready,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [ADDR_W-1:0]  addr_out,
  output logic [DATA_W-1:0]  data_out,
  output logic [BURST_W-1:0] burst_counter,
  output logic               rx_done,
  output logic [1:0]         err
);

  rx_state_e state_q, state_d;

  logic               write_mode_q, write_mode_d;
  logic [ADDR_W-1:0]  addr_out_q, addr_out_d;
  logic [ADDR_W-1:0]  next_addr_q, next_addr_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               wr_valid_q, wr_valid_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [1:0]         err_q, err_d;

  logic               start_ok;
  logic               addr_shift, burst_shift, data_shift, shift_clear;
  logic [ADDR_W-1:0]  addr_word;
  logic [BURST_W-1:0] burst_word;
  logic [DATA_W-1:0]  data_word;
  logic               addr_full, burst_full, data_full;

  assign start_ok    = (state_q == IDLE) && m_valid && (write_enable != read_enable);
  assign addr_shift  = start_ok || ((state_q == ADDR) && m_valid);
  assign burst_shift = (state_q == BURST) && m_valid;
  assign data_shift  = (state_q == WDATA) && m_valid;
  assign shift_clear = (state_q != IDLE) && (state_d == IDLE);

  sbus_shift_in #(.W(ADDR_W)) u_addr_shift (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (shift_clear),
    .shift_en (addr_shift),
    .bit_in   (rx_address),
    .word     (addr_word),
    .full     (addr_full)
  );

  sbus_shift_in #(.W(BURST_W)) u_burst_shift (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (shift_clear),
    .shift_en (burst_shift),
    .bit_in   (rx_address),
    .word     (burst_word),
    .full     (burst_full)
  );

  sbus_shift_in #(.W(DATA_W)) u_data_shift (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (shift_clear),
    .shift_en (data_shift),
    .bit_in   (rx_data),
    .word     (data_word),
    .full     (data_full)
  );

  // A pending write beat survives an abort and is only retired by wr_ready.
  always_comb begin
    state_d      = state_q;
    write_mode_d = write_mode_q;
    addr_out_d   = addr_out_q;
    next_addr_d  = next_addr_q;
    data_out_d   = data_out_q;
    wr_valid_d   = wr_valid_q;
    burst_d      = burst_q;
    err_d        = err_q;

    if (wr_valid_q && wr_ready) begin
      wr_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          write_mode_d = write_enable;
          state_d      = ADDR;
        end else if (m_valid) begin
          err_d[1] = 1'b1;
        end
      end
      ADDR: begin
        if (!m_valid) begin
          state_d  = IDLE;
          err_d[1] = 1'b1;
        end else if (addr_full) begin
          state_d = BURST;
        end
      end
      BURST: begin
        if (!m_valid) begin
          state_d  = IDLE;
          err_d[1] = 1'b1;
        end else if (burst_full) begin
          if (burst_word == '0) begin
            state_d = DONE;
          end else begin
            burst_d     = burst_word;
            next_addr_d = addr_word;
            addr_out_d  = addr_word;
            state_d     = write_mode_q ? WDATA : RDREQ;
          end
        end
      end
      WDATA: begin
        if (!m_valid) begin
          state_d  = IDLE;
          err_d[1] = 1'b1;
        end else if (data_full) begin
          data_out_d  = data_word;
          wr_valid_d  = 1'b1;
          addr_out_d  = next_addr_q;
          next_addr_d = next_addr_q + ADDR_W'(1);
          if (wr_valid_q && !wr_ready) begin
            err_d[0] = 1'b1;
          end
          if (burst_q != '0) begin
            burst_d = burst_q - BURST_W'(1);
          end
          if (burst_q <= BURST_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      RDREQ: begin
        if (!m_valid) begin
          state_d  = IDLE;
          err_d[1] = 1'b1;
        end else if (rd_ready) begin
          addr_out_d = addr_out_q + ADDR_W'(1);
          if (burst_q != '0) begin
            burst_d = burst_q - BURST_W'(1);
          end
          if (burst_q <= BURST_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      write_mode_q <= 1'b0;
      addr_out_q   <= '0;
      next_addr_q  <= '0;
      data_out_q   <= '0;
      wr_valid_q   <= 1'b0;
      burst_q      <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      write_mode_q <= write_mode_d;
      addr_out_q   <= addr_out_d;
      next_addr_q  <= next_addr_d;
      data_out_q   <= data_out_d;
      wr_valid_q   <= wr_valid_d;
      burst_q      <= burst_d;
      err_q        <= err_d;
    end
  end

  assign s_ready       = (state_q == IDLE);
  assign rd_valid      = (state_q == RDREQ);
  assign rx_done       = (state_q == DONE);
  assign wr_valid      = wr_valid_q;
  assign addr_out      = addr_out_q;
  assign data_out      = data_out_q;
  assign burst_counter = burst_q;
  assign err           = err_q;

endmodule

// File: tb/tb_slave_rx_engine.sv
// Directed bench for slave_rx_engine (BURST_W=4) with a write-beat and a read-request scoreboard.
module tb_slave_rx_engine;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_beat_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m_valid, write_enable, read_enable, rx_address, rx_data;
  logic        wr_ready, rd_ready;
  logic        s_ready, wr_valid, rd_valid, rx_done;
  logic [11:0] addr_out;
  logic [7:0]  data_out;
  logic [3:0]  burst_counter;
  logic [1:0]  err;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int done_mark;

  wr_beat_t    wr_q[$];
  logic [11:0] rd_q[$];

  slave_rx_engine #(.ADDR_W(12), .DATA_W(8), .BURST_W(4)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .m_valid       (m_valid),
    .write_enable  (write_enable),
    .read_enable   (read_enable),
    .rx_address    (rx_address),
    .rx_data       (rx_data),
    .s_ready       (s_ready),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .addr_out      (addr_out),
    .data_out      (data_out),
    .burst_counter (burst_counter),
    .rx_done       (rx_done),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives the start bit, the remaining address bits and the 4-bit burst field.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [11:0] base, input logic [3:0] n);
    m_valid      = 1'b1;
    write_enable = wr;
    read_enable  = rd;
    rx_address   = base[11];
    step();
    write_enable = 1'b0;
    read_enable  = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      rx_address = base[i];
      step();
    end
    for (int i = 3; i >= 0; i--) begin
      rx_address = n[i];
      step();
    end
    rx_address = 1'b0;
  endtask

  task automatic sendWord(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      rx_data = w[i];
      step();
    end
    rx_data = 1'b0;
  endtask

  task automatic expectWrite(input logic [11:0] a, input logic [7:0] d);
    wr_beat_t b;
    b.addr = a;
    b.data = d;
    wr_q.push_back(b);
  endtask

  task automatic doReset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    wr_q.delete();
    rd_q.delete();
    step();
  endtask

  // Handshakes complete at the next rising edge, so they are observed on the falling edge before it.
  always @(negedge clk) begin : monitor
    wr_beat_t    e;
    logic [11:0] ra;
    if (rstn) begin
      if (rx_done) done_count++;
      if (wr_valid && wr_ready) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $error("[TB] FAIL unexpectedWrite observed addr=0x%0h data=0x%0h expected=none", addr_out, data_out);
        end else begin
          e = wr_q.pop_front();
          checkOutput("wrBeatAddr", 32'(addr_out), 32'(e.addr));
          checkOutput("wrBeatData", 32'(data_out), 32'(e.data));
        end
      end
      if (rd_valid && rd_ready) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $error("[TB] FAIL unexpectedRead observed addr=0x%0h expected=none", addr_out);
        end else begin
          ra = rd_q.pop_front();
          checkOutput("rdReqAddr", 32'(addr_out), 32'(ra));
        end
      end
    end
  end

  initial begin
    rstn         = 1'b0;
    m_valid      = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    rx_address   = 1'b0;
    rx_data      = 1'b0;
    wr_ready     = 1'b0;
    rd_ready     = 1'b0;

    // Reset state
    step();
    step();
    checkOutput("rstSReady", 32'(s_ready), 1);
    checkOutput("rstWrValid", 32'(wr_valid), 0);
    checkOutput("rstRdValid", 32'(rd_valid), 0);
    checkOutput("rstAddr", 32'(addr_out), 0);
    checkOutput("rstData", 32'(data_out), 0);
    checkOutput("rstBurst", 32'(burst_counter), 0);
    checkOutput("rstDone", 32'(rx_done), 0);
    checkOutput("rstErr", 32'(err), 0);
    rstn = 1'b1;
    step();

    // Write base 0xA5C, two beats, sink always ready
    wr_ready  = 1'b1;
    done_mark = done_count;
    applyStimulus(1'b1, 1'b0, 12'hA5C, 4'd2);
    checkOutput("w1SReadyBusy", 32'(s_ready), 0);
    checkOutput("w1BurstLoad", 32'(burst_counter), 2);
    expectWrite(12'hA5C, 8'h3C);
    sendWord(8'h3C);
    checkOutput("w1Beat0Valid", 32'(wr_valid), 1);
    checkOutput("w1Beat0Addr", 32'(addr_out), 32'hA5C);
    checkOutput("w1Beat0Data", 32'(data_out), 32'h3C);
    checkOutput("w1BurstAfter0", 32'(burst_counter), 1);
    expectWrite(12'hA5D, 8'hF0);
    sendWord(8'hF0);
    checkOutput("w1Done", 32'(rx_done), 1);
    checkOutput("w1Beat1Addr", 32'(addr_out), 32'hA5D);
    checkOutput("w1Beat1Data", 32'(data_out), 32'hF0);
    checkOutput("w1BurstEnd", 32'(burst_counter), 0);
    m_valid = 1'b0;
    step();
    checkOutput("w1Idle", 32'(s_ready), 1);
    checkOutput("w1DoneDrop", 32'(rx_done), 0);
    checkOutput("w1DonePulses", 32'(done_count - done_mark), 1);
    checkOutput("w1WrValidClr", 32'(wr_valid), 0);
    checkOutput("w1SbEmpty", 32'(wr_q.size()), 0);
    checkOutput("w1Err", 32'(err), 0);

    // Address wrap from 0xFFF
    applyStimulus(1'b1, 1'b0, 12'hFFF, 4'd2);
    expectWrite(12'hFFF, 8'h11);
    sendWord(8'h11);
    checkOutput("wrapAddr0", 32'(addr_out), 32'hFFF);
    expectWrite(12'h000, 8'h22);
    sendWord(8'h22);
    checkOutput("wrapAddr1", 32'(addr_out), 32'h000);
    m_valid = 1'b0;
    step();
    checkOutput("wrapSbEmpty", 32'(wr_q.size()), 0);

    // Read base 0x010, three requests, stalled two cycles first
    rd_ready = 1'b0;
    applyStimulus(1'b0, 1'b1, 12'h010, 4'd3);
    rd_q.push_back(12'h010);
    rd_q.push_back(12'h011);
    rd_q.push_back(12'h012);
    for (int c = 0; c < 2; c++) begin
      checkOutput("rdStallValid", 32'(rd_valid), 1);
      checkOutput("rdStallAddr", 32'(addr_out), 32'h010);
      checkOutput("rdStallBurst", 32'(burst_counter), 3);
      step();
    end
    rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("rdValid", 32'(rd_valid), 1);
      checkOutput("rdAddr", 32'(addr_out), 32'h010 + 32'(k));
      checkOutput("rdBurst", 32'(burst_counter), 32'(3 - k));
      step();
    end
    checkOutput("rdValidEnd", 32'(rd_valid), 0);
    checkOutput("rdDone", 32'(rx_done), 1);
    checkOutput("rdBurstEnd", 32'(burst_counter), 0);
    m_valid  = 1'b0;
    rd_ready = 1'b0;
    step();
    checkOutput("rdSbEmpty", 32'(rd_q.size()), 0);

    // Zero-length burst goes straight to completion
    done_mark = done_count;
    applyStimulus(1'b1, 1'b0, 12'h123, 4'd0);
    checkOutput("zeroDone", 32'(rx_done), 1);
    checkOutput("zeroWrValid", 32'(wr_valid), 0);
    m_valid = 1'b0;
    step();
    checkOutput("zeroDonePulses", 32'(done_count - done_mark), 1);

    // Overflow: sink never ready, second word overwrites the first
    wr_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 12'h400, 4'd2);
    sendWord(8'hAA);
    checkOutput("ovfBeat0Valid", 32'(wr_valid), 1);
    checkOutput("ovfErrBefore", 32'(err), 0);
    expectWrite(12'h401, 8'h55);
    sendWord(8'h55);
    checkOutput("ovfData", 32'(data_out), 32'h55);
    checkOutput("ovfAddr", 32'(addr_out), 32'h401);
    checkOutput("ovfErr", 32'(err), 32'h1);
    m_valid = 1'b0;
    step();
    checkOutput("ovfPending", 32'(wr_valid), 1);
    wr_ready = 1'b1;
    step();
    checkOutput("ovfDrained", 32'(wr_valid), 0);
    checkOutput("ovfSbEmpty", 32'(wr_q.size()), 0);

    // Illegal start with both enables, then with neither
    doReset();
    checkOutput("errClearedByReset", 32'(err), 0);
    done_mark    = done_count;
    m_valid      = 1'b1;
    write_enable = 1'b1;
    read_enable  = 1'b1;
    step();
    checkOutput("bothEnIdle", 32'(s_ready), 1);
    checkOutput("bothEnErr", 32'(err), 32'h2);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    step();
    checkOutput("noEnIdle", 32'(s_ready), 1);
    m_valid = 1'b0;
    step();
    checkOutput("badStartNoDone", 32'(done_count - done_mark), 0);

    // Abort in the middle of the address phase
    doReset();
    done_mark    = done_count;
    m_valid      = 1'b1;
    write_enable = 1'b1;
    rx_address   = 1'b1;
    step();
    write_enable = 1'b0;
    repeat (4) step();
    checkOutput("abortBusy", 32'(s_ready), 0);
    m_valid = 1'b0;
    step();
    checkOutput("abortIdle", 32'(s_ready), 1);
    checkOutput("abortErr", 32'(err), 32'h2);
    checkOutput("abortWrValid", 32'(wr_valid), 0);
    checkOutput("abortNoDone", 32'(done_count - done_mark), 0);
    rx_address = 1'b0;
    applyStimulus(1'b1, 1'b0, 12'h200, 4'd1);
    expectWrite(12'h200, 8'h5A);
    sendWord(8'h5A);
    checkOutput("afterAbortDone", 32'(rx_done), 1);
    m_valid = 1'b0;
    step();
    checkOutput("errSticky", 32'(err), 32'h2);
    checkOutput("afterAbortSbEmpty", 32'(wr_q.size()), 0);

    // Reset asserted while the second word is shifting in, with the first still pending
    wr_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 12'h300, 4'd2);
    sendWord(8'h81);
    for (int i = 0; i < 4; i++) begin
      rx_data = 1'b1;
      step();
    end
    rstn = 1'b0;
    #1;
    checkOutput("midRstSReady", 32'(s_ready), 1);
    checkOutput("midRstWrValid", 32'(wr_valid), 0);
    checkOutput("midRstRdValid", 32'(rd_valid), 0);
    checkOutput("midRstAddr", 32'(addr_out), 0);
    checkOutput("midRstData", 32'(data_out), 0);
    checkOutput("midRstBurst", 32'(burst_counter), 0);
    checkOutput("midRstDone", 32'(rx_done), 0);
    checkOutput("midRstErr", 32'(err), 0);
    m_valid = 1'b0;
    rx_data = 1'b0;
    wr_q.delete();
    step();
    step();
    rstn = 1'b1;
    step();
    wr_ready  = 1'b1;
    done_mark = done_count;
    applyStimulus(1'b1, 1'b0, 12'h7F0, 4'd1);
    expectWrite(12'h7F0, 8'hC3);
    sendWord(8'hC3);
    checkOutput("postRstDone", 32'(rx_done), 1);
    checkOutput("postRstAddr", 32'(addr_out), 32'h7F0);
    checkOutput("postRstData", 32'(data_out), 32'hC3);
    m_valid = 1'b0;
    step();
    checkOutput("postRstDonePulses", 32'(done_count - done_mark), 1);
    checkOutput("postRstSbEmpty", 32'(wr_q.size()), 0);
    checkOutput("postRstErr", 32'(err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
